// File: rtl/axi_lite_wr_router.sv
// AXI-Lite write router: round-robin arbitration over NUMBER_MASTER write
// masters, address decode against per-slave offset/range windows, and
// forwarding of AW, W and B for a single transaction at a time. Addresses
// that hit no window are completed internally with a DECERR response.
`timescale 1ns/1ps

module axi_lite_wr_router #(
   parameter int NUMBER_MASTER  = 2,
   parameter int NUMBER_SLAVE   = 4,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] =
      '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000},
   parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE [NUMBER_SLAVE] =
      '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF}
) (
   input  logic                                         aclk,
   input  logic                                         aresetn,
   // upstream (master-facing) ports
   input  logic [NUMBER_MASTER*AXI_ADDR_WIDTH-1:0]      s_axi_awaddr,
   input  logic [NUMBER_MASTER-1:0]                     s_axi_awvalid,
   output logic [NUMBER_MASTER-1:0]                     s_axi_awready,
   input  logic [NUMBER_MASTER*AXI_DATA_WIDTH-1:0]      s_axi_wdata,
   input  logic [NUMBER_MASTER*(AXI_DATA_WIDTH/8)-1:0]  s_axi_wstrb,
   input  logic [NUMBER_MASTER-1:0]                     s_axi_wvalid,
   output logic [NUMBER_MASTER-1:0]                     s_axi_wready,
   output logic [NUMBER_MASTER*2-1:0]                   s_axi_bresp,
   output logic [NUMBER_MASTER-1:0]                     s_axi_bvalid,
   input  logic [NUMBER_MASTER-1:0]                     s_axi_bready,
   // downstream (slave-facing) ports
   output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
   output logic [NUMBER_SLAVE-1:0]                      m_axi_awvalid,
   input  logic [NUMBER_SLAVE-1:0]                      m_axi_awready,
   output logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0]       m_axi_wdata,
   output logic [NUMBER_SLAVE*(AXI_DATA_WIDTH/8)-1:0]   m_axi_wstrb,
   output logic [NUMBER_SLAVE-1:0]                      m_axi_wvalid,
   input  logic [NUMBER_SLAVE-1:0]                      m_axi_wready,
   input  logic [NUMBER_SLAVE*2-1:0]                    m_axi_bresp,
   input  logic [NUMBER_SLAVE-1:0]                      m_axi_bvalid,
   output logic [NUMBER_SLAVE-1:0]                      m_axi_bready
);

   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
   localparam int MST_W      = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
   localparam int SLV_W      = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Window test done one bit wider than the address so offset+range never wraps.
   function automatic logic window_hit(
      input logic [AXI_ADDR_WIDTH-1:0] addr,
      input logic [AXI_ADDR_WIDTH-1:0] base,
      input logic [AXI_ADDR_WIDTH-1:0] span
   );
      logic [AXI_ADDR_WIDTH:0] top;
      top = {1'b0, base} + {1'b0, span};
      return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= top);
   endfunction

   // unpacked views of the flat per-port buses
   logic [AXI_ADDR_WIDTH-1:0] s_awaddr_a [NUMBER_MASTER];
   logic [AXI_DATA_WIDTH-1:0] s_wdata_a  [NUMBER_MASTER];
   logic [STRB_WIDTH-1:0]     s_wstrb_a  [NUMBER_MASTER];
   logic [1:0]                s_bresp_a  [NUMBER_MASTER];
   logic [AXI_ADDR_WIDTH-1:0] m_awaddr_a [NUMBER_SLAVE];
   logic [AXI_DATA_WIDTH-1:0] m_wdata_a  [NUMBER_SLAVE];
   logic [STRB_WIDTH-1:0]     m_wstrb_a  [NUMBER_SLAVE];
   logic [1:0]                m_bresp_a  [NUMBER_SLAVE];

   // transaction context
   state_t                    state_r;
   state_t                    next_state_s;
   logic [MST_W-1:0]          grant_r;
   logic [MST_W-1:0]          rr_ptr_r;
   logic [SLV_W-1:0]          slave_r;
   logic                      miss_r;
   logic [AXI_ADDR_WIDTH-1:0] addr_r;
   logic                      aw_done_r;
   logic                      w_done_r;

   // arbitration / decode / handshake strobes
   logic [MST_W-1:0]          arb_idx_s;
   logic                      arb_found_s;
   int                        arb_scan_s;
   logic [SLV_W-1:0]          dec_idx_s;
   logic                      dec_hit_s;
   logic                      aw_fire_s;
   logic                      w_fire_s;
   logic                      b_fire_s;
   logic [MST_W-1:0]          next_ptr_s;

   for (genvar i = 0; i < NUMBER_MASTER; i++) begin : g_mst
      assign s_awaddr_a[i] = s_axi_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign s_wdata_a[i]  = s_axi_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      assign s_wstrb_a[i]  = s_axi_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
      assign s_axi_bresp[i*2 +: 2] = s_bresp_a[i];
   end

   for (genvar j = 0; j < NUMBER_SLAVE; j++) begin : g_slv
      assign m_axi_awaddr[j*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = m_awaddr_a[j];
      assign m_axi_wdata[j*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]  = m_wdata_a[j];
      assign m_axi_wstrb[j*STRB_WIDTH +: STRB_WIDTH]          = m_wstrb_a[j];
      assign m_bresp_a[j] = m_axi_bresp[j*2 +: 2];
   end

   // Round-robin pick: first requesting master at or above rr_ptr, wrapping.
   always_comb begin
      arb_idx_s   = '0;
      arb_found_s = 1'b0;
      arb_scan_s  = 0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         arb_scan_s = (int'(rr_ptr_r) + i) % NUMBER_MASTER;
         if (!arb_found_s && s_axi_awvalid[arb_scan_s]) begin
            arb_idx_s   = MST_W'(arb_scan_s);
            arb_found_s = 1'b1;
         end else begin
            arb_found_s = arb_found_s;
         end
      end
   end

   // Address decode of the candidate master; scanning downward lets the lowest window win.
   always_comb begin
      dec_hit_s = 1'b0;
      dec_idx_s = '0;
      for (int j = NUMBER_SLAVE - 1; j >= 0; j--) begin
         if (window_hit(s_awaddr_a[arb_idx_s], AXI_ADDR_OFFSET[j], AXI_ADDR_RANGE[j])) begin
            dec_hit_s = 1'b1;
            dec_idx_s = SLV_W'(j);
         end else begin
            dec_hit_s = dec_hit_s;
         end
      end
   end

   // Pointer for the next arbitration round: one past the finished grant.
   always_comb begin
      if (grant_r == MST_W'(NUMBER_MASTER - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_r + MST_W'(1);
      end
   end

   // FSM state register; reset abandons any in-flight transaction.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Capture grant/decode in IDLE, track AW/W completion, advance rr_ptr on B.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grant_r   <= '0;
         rr_ptr_r  <= '0;
         slave_r   <= '0;
         miss_r    <= 1'b0;
         addr_r    <= '0;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|s_axi_awvalid) begin
                  grant_r   <= arb_idx_s;
                  addr_r    <= s_awaddr_a[arb_idx_s];
                  slave_r   <= dec_idx_s;
                  miss_r    <= ~dec_hit_s;
                  aw_done_r <= 1'b0;
                  w_done_r  <= 1'b0;
               end
            end
            ST_ADDR: begin
               if (aw_fire_s) begin
                  aw_done_r <= 1'b1;
               end
               if (w_fire_s) begin
                  w_done_r <= 1'b1;
               end
            end
            ST_RESP: begin
               if (b_fire_s) begin
                  rr_ptr_r  <= next_ptr_s;
                  aw_done_r <= 1'b0;
                  w_done_r  <= 1'b0;
               end
            end
            default: begin
               aw_done_r <= 1'b0;
               w_done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Next state and port routing; everything defaults to zero so idle and
   // non-granted ports stay quiet and reset silences all outputs at once.
   always_comb begin
      next_state_s  = state_r;
      s_axi_awready = '0;
      s_axi_wready  = '0;
      s_axi_bvalid  = '0;
      m_axi_awvalid = '0;
      m_axi_wvalid  = '0;
      m_axi_bready  = '0;
      aw_fire_s     = 1'b0;
      w_fire_s      = 1'b0;
      b_fire_s      = 1'b0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         s_bresp_a[i] = RESP_OKAY;
      end
      for (int j = 0; j < NUMBER_SLAVE; j++) begin
         m_awaddr_a[j] = '0;
         m_wdata_a[j]  = '0;
         m_wstrb_a[j]  = '0;
      end

      case (state_r)
         ST_IDLE: begin
            if (|s_axi_awvalid) begin
               next_state_s = ST_ADDR;
            end else begin
               next_state_s = ST_IDLE;
            end
         end

         ST_ADDR: begin
            if (miss_r) begin
               // unmapped: accept AW and W locally, nothing goes downstream
               s_axi_awready[grant_r] = ~aw_done_r;
               s_axi_wready[grant_r]  = ~w_done_r;
               aw_fire_s = s_axi_awvalid[grant_r] & ~aw_done_r;
               w_fire_s  = s_axi_wvalid[grant_r] & ~w_done_r;
            end else begin
               // AW comes from the registered address, W is a live pass-through
               m_axi_awvalid[slave_r] = ~aw_done_r;
               m_awaddr_a[slave_r]    = addr_r;
               s_axi_awready[grant_r] = m_axi_awready[slave_r] & ~aw_done_r;
               m_axi_wvalid[slave_r]  = s_axi_wvalid[grant_r] & ~w_done_r;
               m_wdata_a[slave_r]     = s_wdata_a[grant_r];
               m_wstrb_a[slave_r]     = s_wstrb_a[grant_r];
               s_axi_wready[grant_r]  = m_axi_wready[slave_r] & ~w_done_r;
               aw_fire_s = m_axi_awready[slave_r] & ~aw_done_r;
               w_fire_s  = s_axi_wvalid[grant_r] & m_axi_wready[slave_r] & ~w_done_r;
            end
            if ((aw_done_r | aw_fire_s) & (w_done_r | w_fire_s)) begin
               next_state_s = ST_RESP;
            end else begin
               next_state_s = ST_ADDR;
            end
         end

         ST_RESP: begin
            if (miss_r) begin
               s_axi_bvalid[grant_r] = 1'b1;
               s_bresp_a[grant_r]    = RESP_DECERR;
               b_fire_s = s_axi_bready[grant_r];
            end else begin
               s_axi_bvalid[grant_r] = m_axi_bvalid[slave_r];
               s_bresp_a[grant_r]    = m_bresp_a[slave_r];
               m_axi_bready[slave_r] = s_axi_bready[grant_r];
               b_fire_s = m_axi_bvalid[slave_r] & s_axi_bready[grant_r];
            end
            if (b_fire_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end

         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_lite_wr_router.sv
// Self-checking bench for axi_lite_wr_router: a table of directed writes,
// randomized writes checked against a window-map reference model, and
// hand-written reset and round-robin sequences.
`timescale 1ns/1ps

module tb_axi_lite_wr_router;

   localparam int NM = 2;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic                aclk = 1'b0;
   logic                aresetn;
   logic [NM*AW-1:0]    s_axi_awaddr;
   logic [NM-1:0]       s_axi_awvalid, s_axi_awready;
   logic [NM*DW-1:0]    s_axi_wdata;
   logic [NM*SW-1:0]    s_axi_wstrb;
   logic [NM-1:0]       s_axi_wvalid, s_axi_wready;
   logic [NM*2-1:0]     s_axi_bresp;
   logic [NM-1:0]       s_axi_bvalid, s_axi_bready;
   logic [NS*AW-1:0]    m_axi_awaddr;
   logic [NS-1:0]       m_axi_awvalid, m_axi_awready;
   logic [NS*DW-1:0]    m_axi_wdata;
   logic [NS*SW-1:0]    m_axi_wstrb;
   logic [NS-1:0]       m_axi_wvalid, m_axi_wready;
   logic [NS*2-1:0]     m_axi_bresp;
   logic [NS-1:0]       m_axi_bvalid, m_axi_bready;

   axi_lite_wr_router dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   always #5 aclk = ~aclk;

   int tests_run    = 0;
   int tests_failed = 0;

   // address map known to the bench
   logic [31:0] win_base [NS] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
   logic [31:0] win_span [NS] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};
   logic [31:0] edge_addr [6] = '{32'h3000_FFFF, 32'h3001_0000, 32'h0FFF_FFFF,
                                  32'h1000_0000, 32'h4000_FFFF, 32'h1001_0000};

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_start;
      int          w_start;
      int          aw_lat;
      int          w_lat;
      logic [1:0]  sresp;
      int          exp_slave;
      logic [1:0]  exp_bresp;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // reference decode: index of the first window containing a, or -1
   function automatic int ref_decode(input logic [31:0] a);
      longint lo, hi, av;
      av = longint'({32'h0, a});
      for (int j = 0; j < NS; j++) begin
         lo = longint'({32'h0, win_base[j]});
         hi = lo + longint'({32'h0, win_span[j]});
         if (av >= lo && av <= hi) return j;
      end
      return -1;
   endfunction

   function automatic logic [63:0] outputs_or();
      return {39'h0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
              m_axi_awvalid, m_axi_wvalid, m_axi_bready,
              |m_axi_awaddr, |m_axi_wdata, |m_axi_wstrb};
   endfunction

   task automatic clear_inputs();
      s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_bready = '0;
      m_axi_awready = '0; m_axi_wready = '0; m_axi_bvalid = '0; m_axi_bresp = '0;
   endtask

   // One write from master m; slave side emulated with awready/wready after
   // aw_lat/w_lat cycles of valid. Starts and ends on a negedge.
   task automatic run_txn(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_start, input int w_start,
                          input int aw_lat, input int w_lat, input logic [1:0] sresp,
                          input int es, input logic [1:0] exp_bresp, input string tag);
      int  aw_cnt = 0, w_cnt = 0, slv_aw_hs = 0, slv_w_hs = 0, first_aw = -1;
      int  om = 1 - m;
      bit  m_aw_done = 0, m_w_done = 0, b_sent = 0, done = 0, stray = 0, data_bad = 0;
      bit  awv_pre, awr_pre, wv_pre, wr_pre, aw_m, w_m, b_hs, bs_hs;
      logic [1:0] got_bresp = 2'b00;
      s_axi_awaddr[m*AW +: AW] = addr;
      s_axi_wdata[m*DW +: DW]  = data;
      s_axi_wstrb[m*SW +: SW]  = strb;
      for (int k = 0; k < 300 && !done; k++) begin
         s_axi_awvalid[m] = (k >= aw_start) && !m_aw_done;
         s_axi_wvalid[m]  = (k >= w_start) && !m_w_done;
         s_axi_bready[m]  = 1'b1;
         m_axi_awready = '0; m_axi_wready = '0; m_axi_bvalid = '0; m_axi_bresp = '0;
         if (es >= 0) begin
            m_axi_awready[es] = (aw_cnt >= aw_lat);
            m_axi_wready[es]  = (w_cnt >= w_lat);
            m_axi_bvalid[es]  = (slv_aw_hs > 0) && (slv_w_hs > 0) && !b_sent;
            m_axi_bresp[es*2 +: 2] = sresp;
         end
         #1;
         awv_pre = 0; awr_pre = 0; wv_pre = 0; wr_pre = 0; bs_hs = 0;
         if (es < 0) begin
            if (m_axi_awvalid != '0 || m_axi_wvalid != '0 || m_axi_bready != '0) stray = 1;
         end else begin
            for (int j = 0; j < NS; j++)
               if (j != es && (m_axi_awvalid[j] || m_axi_wvalid[j] || m_axi_bready[j])) stray = 1;
            awv_pre = m_axi_awvalid[es]; awr_pre = m_axi_awready[es];
            wv_pre  = m_axi_wvalid[es];  wr_pre  = m_axi_wready[es];
            if (awv_pre && first_aw < 0) first_aw = k;
            if (awv_pre && awr_pre) begin
               slv_aw_hs++;
               if (m_axi_awaddr[es*AW +: AW] !== addr) data_bad = 1;
            end
            if (wv_pre && wr_pre) begin
               slv_w_hs++;
               if (m_axi_wdata[es*DW +: DW] !== data || m_axi_wstrb[es*SW +: SW] !== strb) data_bad = 1;
            end
            bs_hs = m_axi_bvalid[es] && m_axi_bready[es];
         end
         if (s_axi_awready[om] || s_axi_wready[om] || s_axi_bvalid[om]) stray = 1;
         if (k <= aw_start && (s_axi_awready[m] || s_axi_wready[m])) stray = 1;
         aw_m = s_axi_awvalid[m] && s_axi_awready[m];
         w_m  = s_axi_wvalid[m] && s_axi_wready[m];
         b_hs = s_axi_bvalid[m] && s_axi_bready[m];
         if (b_hs) got_bresp = s_axi_bresp[m*2 +: 2];
         @(posedge aclk);
         if (awv_pre && !awr_pre) aw_cnt++;
         if (wv_pre && !wr_pre) w_cnt++;
         if (aw_m) m_aw_done = 1;
         if (w_m) m_w_done = 1;
         if (bs_hs) b_sent = 1;
         if (b_hs) done = 1;
         @(negedge aclk);
      end
      clear_inputs();
      check($sformatf("%s completed", tag), 64'(done), 64'd1);
      check($sformatf("%s bresp", tag), 64'(got_bresp), 64'(exp_bresp));
      check($sformatf("%s no stray activity", tag), 64'(stray), 64'd0);
      if (es >= 0) begin
         check($sformatf("%s slave AW count", tag), 64'(slv_aw_hs), 64'd1);
         check($sformatf("%s slave W count", tag), 64'(slv_w_hs), 64'd1);
         check($sformatf("%s payload", tag), 64'(data_bad), 64'd0);
         check($sformatf("%s AW latency", tag), 64'(first_aw), 64'(aw_start + 1));
      end
   endtask

   // safety net so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int es, rr_m, nb, last_k;
      logic [31:0] addr;
      logic [1:0]  sresp;

      vecs[0]  = '{0, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00,  1, 2'b00};
      vecs[1]  = '{1, 32'h5000_0000, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 2'b00, -1, 2'b11};
      vecs[2]  = '{0, 32'h3000_FFFF, 32'hA5A5_A5A5, 4'h3, 0, 0, 1, 1, 2'b10,  2, 2'b10};
      vecs[3]  = '{1, 32'h3001_0000, 32'h0BAD_0BAD, 4'hF, 0, 0, 0, 0, 2'b00, -1, 2'b11};
      vecs[4]  = '{0, 32'h0FFF_FFFF, 32'h7777_8888, 4'hF, 0, 0, 0, 0, 2'b00, -1, 2'b11};
      vecs[5]  = '{1, 32'h1000_0000, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 0, 2'b01,  0, 2'b01};
      vecs[6]  = '{0, 32'h4000_FFFF, 32'h0000_0001, 4'h1, 0, 0, 2, 0, 2'b00,  3, 2'b00};
      vecs[7]  = '{1, 32'h4001_0000, 32'h9999_0000, 4'hF, 0, 0, 0, 0, 2'b00, -1, 2'b11};
      vecs[8]  = '{0, 32'h4000_1234, 32'h1111_2222, 4'hF, 3, 0, 5, 2, 2'b00,  3, 2'b00};
      vecs[9]  = '{1, 32'h2000_FFFC, 32'h3333_4444, 4'hF, 0, 0, 4, 4, 2'b00,  1, 2'b00};
      vecs[10] = '{0, 32'h6000_0000, 32'h5555_6666, 4'hF, 2, 0, 0, 0, 2'b00, -1, 2'b11};
      vecs[11] = '{1, 32'h1000_FFFF, 32'h5555_AAAA, 4'hF, 0, 2, 3, 0, 2'b11,  0, 2'b11};

      aresetn = 1'b0;
      s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
      clear_inputs();
      repeat (3) @(negedge aclk);
      check("reset outputs zero", outputs_or(), 64'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("idle outputs zero", outputs_or(), 64'd0);

      // directed table
      for (int v = 0; v < 12; v++) begin
         run_txn(vecs[v].m, vecs[v].addr, vecs[v].data, vecs[v].strb,
                 vecs[v].aw_start, vecs[v].w_start, vecs[v].aw_lat, vecs[v].w_lat,
                 vecs[v].sresp, vecs[v].exp_slave, vecs[v].exp_bresp,
                 $sformatf("vec%0d", v));
      end

      // randomized writes against the reference map
      for (int r = 0; r < 60; r++) begin
         case ($urandom_range(0, 5))
            0, 1, 2, 3: addr = win_base[$urandom_range(0, NS - 1)] + 32'($urandom_range(0, 32'hFFFF));
            4:          addr = $urandom;
            default:    addr = edge_addr[$urandom_range(0, 5)];
         endcase
         sresp = 2'($urandom_range(0, 3));
         es = ref_decode(addr);
         run_txn(int'($urandom_range(0, NM - 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(2, 17)), int'($urandom_range(2, 17)),
                 sresp, es, (es < 0) ? 2'b11 : sresp, $sformatf("rnd%0d", r));
      end

      // reset in the middle of an address phase
      s_axi_awaddr[AW +: AW] = 32'h2000_0000;
      s_axi_awvalid = 2'b10; s_axi_wvalid = 2'b10;
      @(negedge aclk);
      #1;
      check("pre-reset awvalid", 64'(m_axi_awvalid), 64'h2);
      #1 aresetn = 1'b0;
      #1;
      check("reset drops awvalid", 64'(m_axi_awvalid), 64'd0);
      check("reset outputs zero mid-txn", outputs_or(), 64'd0);
      clear_inputs();
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // round robin with both masters requesting continuously
      s_axi_awaddr = {32'h2000_0040, 32'h1000_0020};
      s_axi_awvalid = 2'b11; s_axi_wvalid = 2'b11; s_axi_bready = 2'b11;
      m_axi_awready = '1; m_axi_wready = '1; m_axi_bvalid = '1; m_axi_bresp = '0;
      rr_m = 0; nb = 0; last_k = -1;
      for (int k = 0; k < 60 && nb < 5; k++) begin
         #1;
         if (s_axi_bvalid != '0) begin
            check($sformatf("rr grant %0d", nb), 64'(s_axi_bvalid), 64'd1 << rr_m);
            if (nb == 0) check("rr first response cycle", 64'(k), 64'd2);
            else check($sformatf("rr spacing %0d", nb), 64'(k - last_k), 64'd3);
            last_k = k;
            rr_m = (rr_m + 1) % NM;
            nb++;
         end
         @(negedge aclk);
      end
      check("rr transaction count", 64'(nb), 64'd5);
      clear_inputs();
      repeat (4) @(negedge aclk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
